// File: rtl/huffman_sym_fifo.sv
// Symbol buffer behind the Huffman bit-serial decoder: range-checks symbols, queues them in a show-ahead FIFO.
// Define HUFF_SYM_FIFO_STATS_EN to add the saturating sym_count/drop_count statistics ports.
module huffman_sym_fifo #(
    parameter int DEPTH   = 16,
    parameter int SYM_W   = 5,
    parameter int SYM_MIN = 1,
    parameter int SYM_MAX = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SYM_W-1:0]         sym_in,
    input  logic                     sym_valid_in,
    output logic [SYM_W-1:0]         out_symbol,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     range_err,
    input  logic                     clr_flags
`ifdef HUFF_SYM_FIFO_STATS_EN
    ,
    output logic [15:0]              sym_count,
    output logic [7:0]               drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
    localparam logic [SYM_W-1:0] SYM_LO   = SYM_W'(SYM_MIN);
    localparam logic [SYM_W-1:0] SYM_HI   = SYM_W'(SYM_MAX);

    logic [SYM_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic in_range;
    logic push_req;
    logic range_evt;
    logic pop;
    logic push;
    logic ovf_evt;

    assign full       = (level == FULL_LVL);
    assign empty      = (level == '0);
    assign out_valid  = !empty;
    assign out_symbol = empty ? '0 : mem[rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign in_range  = (sym_in >= SYM_LO) && (sym_in <= SYM_HI);
    assign push_req  = sym_valid_in && in_range;
    assign range_evt = sym_valid_in && !in_range;
    assign pop       = out_valid && out_ready;
    assign push      = push_req && (!full || pop);
    assign ovf_evt   = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sym_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            range_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            // A new event in the clearing cycle keeps the flag set.
            overflow  <= ovf_evt   || (overflow  && !clr_flags);
            range_err <= range_evt || (range_err && !clr_flags);
        end
    end

`ifdef HUFF_SYM_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_count  <= '0;
            drop_count <= '0;
        end else begin
            if (clr_flags) begin
                sym_count <= push ? 16'd1 : 16'd0;
            end else if (push && sym_count != 16'hFFFF) begin
                sym_count <= sym_count + 16'd1;
            end
            if (clr_flags) begin
                drop_count <= (ovf_evt || range_evt) ? 8'd1 : 8'd0;
            end else if ((ovf_evt || range_evt) && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: doc/huffman_sym_fifo.md
Name: huffman_sym_fifo

Overview:
- Downstream stage of the Huffman bit-serial decoder.
- Captures each decoded symbol when the decoder pulses valid and buffers it in a synchronous FIFO. Presents the symbols to the consumer over a valid/ready handshake.
- The decoder has no backpressure, so this block absorbs bursts. It drops symbols on overflow or when the symbol is out of range, and reports each case with a sticky flag.

Parameters:
- DEPTH, 16, number of FIFO entries. Must be a power of two, at least 2.
- SYM_W, 5, symbol width in bits; matches the decoder symbol output.
- SYM_MIN, 1, lowest legal symbol value.
- SYM_MAX, 18, highest legal symbol value.

Ports:
- clk  input  1  single clock; all logic updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sym_in  input  SYM_W  decoded symbol from the decoder.
- sym_valid_in  input  1  decoder valid pulse; sym_in is captured on this cycle.
- out_symbol  output  SYM_W  head-of-FIFO symbol.
- out_valid  output  1  FIFO is non-empty; out_symbol is valid.
- out_ready  input  1  consumer accepts out_symbol this cycle.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- overflow  output  1  sticky: a legal symbol was dropped because the FIFO was full.
- range_err  output  1  sticky: a symbol outside SYM_MIN..SYM_MAX was received.
- clr_flags  input  1  synchronous clear of overflow and range_err.

Behaviour:
- Reset: rst is synchronous and active-high. On rst=1 at a rising edge of clk:
  - write pointer, read pointer and level go to 0;
  - out_valid=0, empty=1, full=0, overflow=0, range_err=0;
  - out_symbol=0;
  - memory contents are don't-care.
  - rst overrides every other input in that cycle. Reset mid-stream discards all buffered symbols.
- push = sym_valid_in and SYM_MIN <= sym_in <= SYM_MAX.
- pop = out_valid and out_ready.
- Show-ahead read:
  - out_symbol = mem[rd_ptr]; out_valid = !empty.
  - Write-to-output latency is 1 cycle: a symbol written at edge N is visible after edge N.
  - A push into an empty FIFO does not appear at the output in the same cycle (no combinational bypass).
  - out_symbol is forced to 0 while empty.
- Push accepted when !full, or when full and pop occurs in the same cycle:
  - the entry is written at wr_ptr, wr_ptr increments modulo DEPTH;
  - level increments unless a pop occurs in the same cycle.
- Pop: rd_ptr increments modulo DEPTH; level decrements unless a push is accepted in the same cycle.
- Simultaneous push and pop: level unchanged, both pointers advance.
- Overflow: push while full and no pop → symbol dropped, pointers and level unchanged, overflow set at the next edge.
- Out-of-range symbol: sym_valid_in with sym_in < SYM_MIN or > SYM_MAX →
  - symbol never written;
  - range_err set at the next edge;
  - it never counts as an overflow, even when the FIFO is full.
- Flag clearing: clr_flags=1 clears both flags at the next edge. If a new set event occurs in the same cycle, set wins and the flag stays 1.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. full and empty are derived from level, not from pointer comparison.
- out_ready while empty: no effect.

Optional Feature:
- Macro: HUFF_SYM_FIFO_STATS_EN.
- When defined, two extra ports are added:
  - sym_count (output, 16 bits): counts accepted pushes, saturates at 16'hFFFF.
  - drop_count (output, 8 bits): counts overflow and range drops, saturates at 8'hFF.
- Both counters reset to 0 on rst and also clear on clr_flags. If a count event occurs in the same cycle as clr_flags, the counter loads 1.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset then idle: after rst held 2 cycles → out_valid=0, empty=1, level=0, overflow=0, range_err=0, out_symbol=0.
- Single symbol: push sym_in=7 at edge N with out_ready=0 → after edge N out_valid=1, out_symbol=7, level=1. Raise out_ready for 1 cycle → empty=1.
- Fill and overflow (DEPTH=16, out_ready=0):
  - push symbols 1..16 → full=1, level=16;
  - push 17 → overflow=1, level stays 16;
  - drain → outputs 1..16 in order, 17 never appears.
- Full with simultaneous push/pop: FIFO full of symbols 1..16, push 18 with out_ready=1 → level stays 16, overflow=0. After draining, 18 is the last symbol out.
- Range check: push 0, then 19, then 31 → range_err=1, level=0. Pulse clr_flags → range_err=0. clr_flags in the same cycle as sym_in=0 → range_err stays 1.
- Wrap and reset mid-stream:
  - stream 40 symbols (cycling 1..18) with out_ready toggling every cycle → output order matches input order across pointer wrap;
  - assert rst with level=5 → level=0, out_valid=0 on the next cycle;
  - with HUFF_SYM_FIFO_STATS_EN defined, sym_count=0 after the reset.
